// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module  : alu_pkg
// Brief   : Shared encodings for the multi-cycle ALU control unit.
// Rev     : 1.0  initial release
// ============================================================================
package alu_pkg;

  // ALU operation codes
  localparam logic [3:0] ALU_AND  = 4'b0000;
  localparam logic [3:0] ALU_OR   = 4'b0001;
  localparam logic [3:0] ALU_ADD  = 4'b0010;
  localparam logic [3:0] ALU_XOR  = 4'b0011;
  localparam logic [3:0] ALU_SUB  = 4'b0110;
  localparam logic [3:0] ALU_SLT  = 4'b0111;
  localparam logic [3:0] ALU_SLTU = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b1001;
  localparam logic [3:0] ALU_SRL  = 4'b1010;
  localparam logic [3:0] ALU_SRA  = 4'b1011;
  localparam logic [3:0] ALU_NOR  = 4'b1100;

  // ALUOp from main control
  localparam logic [2:0] AOP_ADD   = 3'b000;
  localparam logic [2:0] AOP_SUB   = 3'b001;
  localparam logic [2:0] AOP_FUNCT = 3'b010;
  localparam logic [2:0] AOP_AND   = 3'b011;
  localparam logic [2:0] AOP_OR    = 3'b100;
  localparam logic [2:0] AOP_SLT   = 3'b101;
  localparam logic [2:0] AOP_XOR   = 3'b110;
  localparam logic [2:0] AOP_SLTU  = 3'b111;

  // R-type funct fields
  localparam logic [5:0] F_SLL   = 6'b000000;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_SRA   = 6'b000011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_ADDU  = 6'b100001;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SUBU  = 6'b100011;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_XOR   = 6'b100110;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SLTU  = 6'b101011;

  // mul/div operation select
  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  // mul/div sequencer states
  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_MD_RUN  = 2'd1;
  localparam logic [1:0] ST_MD_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/alu_funct_dec.sv
`default_nettype none
// ============================================================================
// Module  : alu_funct_dec
// Brief   : Combinational ALUOp/funct decode to ALU code and mul/div select.
// Rev     : 1.0  initial release
// ============================================================================
module alu_funct_dec
  import alu_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int CTRL_W  = 4
) (
  input  logic [2:0]         alu_op_i,
  input  logic [FUNCT_W-1:0] funct_i,
  output logic [CTRL_W-1:0]  alu_ctrl_o,
  output logic               is_md_o,
  output logic [1:0]         md_op_o,
  output logic               illegal_o
);

  logic [3:0] code;

  always_comb begin
    code      = ALU_ADD;
    is_md_o   = 1'b0;
    md_op_o   = MD_MULT;
    illegal_o = 1'b0;
    case (alu_op_i)
      AOP_ADD:  code = ALU_ADD;
      AOP_SUB:  code = ALU_SUB;
      AOP_AND:  code = ALU_AND;
      AOP_OR:   code = ALU_OR;
      AOP_SLT:  code = ALU_SLT;
      AOP_XOR:  code = ALU_XOR;
      AOP_SLTU: code = ALU_SLTU;
      AOP_FUNCT: begin
        case (funct_i)
          FUNCT_W'(F_ADD), FUNCT_W'(F_ADDU): code = ALU_ADD;
          FUNCT_W'(F_SUB), FUNCT_W'(F_SUBU): code = ALU_SUB;
          FUNCT_W'(F_AND):  code = ALU_AND;
          FUNCT_W'(F_OR):   code = ALU_OR;
          FUNCT_W'(F_XOR):  code = ALU_XOR;
          FUNCT_W'(F_NOR):  code = ALU_NOR;
          FUNCT_W'(F_SLT):  code = ALU_SLT;
          FUNCT_W'(F_SLTU): code = ALU_SLTU;
          FUNCT_W'(F_SLL):  code = ALU_SLL;
          FUNCT_W'(F_SRL):  code = ALU_SRL;
          FUNCT_W'(F_SRA):  code = ALU_SRA;
          // mul/div keep the ALU on ADD; the result lands in HI/LO instead
          FUNCT_W'(F_MULT):  begin is_md_o = 1'b1; md_op_o = MD_MULT;  end
          FUNCT_W'(F_MULTU): begin is_md_o = 1'b1; md_op_o = MD_MULTU; end
          FUNCT_W'(F_DIV):   begin is_md_o = 1'b1; md_op_o = MD_DIV;   end
          FUNCT_W'(F_DIVU):  begin is_md_o = 1'b1; md_op_o = MD_DIVU;  end
          default: illegal_o = 1'b1;
        endcase
      end
      default: code = ALU_ADD;
    endcase
  end

  assign alu_ctrl_o = CTRL_W'(code);

endmodule
`default_nettype wire

// File: rtl/alu_control_mc.sv
`default_nettype none
// ============================================================================
// Module  : alu_control_mc
// Brief   : Registered ALU control with valid/ready and a mul/div busy FSM.
// Rev     : 1.0  initial release
// ============================================================================
module alu_control_mc
  import alu_pkg::*;
#(
  parameter int FUNCT_W = 6,
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 32,
  parameter int CNT_W   = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         alu_op,
  input  logic [FUNCT_W-1:0] funct,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [CTRL_W-1:0]  alu_ctrl,
  output logic               md_start,
  output logic [1:0]         md_op,
  output logic               md_busy,
  output logic               hilo_we,
  output logic               illegal
);

  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              out_valid_q, out_valid_d;
  logic [CTRL_W-1:0] alu_ctrl_q, alu_ctrl_d;
  logic              illegal_q, illegal_d;
  logic              md_start_q, md_start_d;
  logic [1:0]        md_op_q, md_op_d;

  logic [CTRL_W-1:0] dec_ctrl;
  logic              dec_is_md;
  logic [1:0]        dec_md_op;
  logic              dec_illegal;
  logic              accept;

  alu_funct_dec #(
    .FUNCT_W (FUNCT_W),
    .CTRL_W  (CTRL_W)
  ) u_dec (
    .alu_op_i   (alu_op),
    .funct_i    (funct),
    .alu_ctrl_o (dec_ctrl),
    .is_md_o    (dec_is_md),
    .md_op_o    (dec_md_op),
    .illegal_o  (dec_illegal)
  );

  assign accept = in_valid && in_ready && !flush;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept && dec_is_md) begin
            state_d = ST_MD_RUN;
            cnt_d   = dec_md_op[1] ? DIV_CNT : MUL_CNT;
          end
        end
        ST_MD_RUN: begin
          if (cnt_q == '0) state_d = ST_MD_DONE;
          else             cnt_d   = cnt_q - 1'b1;
        end
        ST_MD_DONE: state_d = ST_IDLE;
        default:    state_d = ST_IDLE;
      endcase
    end
  end

  // Output holding register
  always_comb begin
    out_valid_d = out_valid_q;
    alu_ctrl_d  = alu_ctrl_q;
    illegal_d   = illegal_q;
    md_start_d  = 1'b0;
    md_op_d     = md_op_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (accept) begin
      out_valid_d = 1'b1;
      alu_ctrl_d  = dec_ctrl;
      illegal_d   = dec_illegal;
      md_start_d  = dec_is_md;
      if (dec_is_md) md_op_d = dec_md_op;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      alu_ctrl_q  <= CTRL_W'(ALU_ADD);
      illegal_q   <= 1'b0;
      md_start_q  <= 1'b0;
      md_op_q     <= MD_MULT;
    end else begin
      out_valid_q <= out_valid_d;
      alu_ctrl_q  <= alu_ctrl_d;
      illegal_q   <= illegal_d;
      md_start_q  <= md_start_d;
      md_op_q     <= md_op_d;
    end
  end

  // Output logic; a flush landing on MD_DONE suppresses the HI/LO write
  always_comb begin
    in_ready  = (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    md_busy   = (state_q != ST_IDLE);
    hilo_we   = (state_q == ST_MD_DONE) && !flush;
    out_valid = out_valid_q;
    alu_ctrl  = alu_ctrl_q;
    illegal   = illegal_q && out_valid_q;
    md_start  = md_start_q;
    md_op     = md_op_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_control_mc.sv
`default_nettype none
// ============================================================================
// Module  : tb_alu_control_mc
// Brief   : Scoreboard bench with a cycle-level reference model of alu_control_mc.
// Rev     : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_control_mc;

  localparam int FUNCT_W = 6;
  localparam int CTRL_W  = 4;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 32;
  localparam int CNT_W   = 6;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [2:0]         alu_op = 3'b000;
  logic [FUNCT_W-1:0] funct = '0;
  logic               flush = 1'b0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [CTRL_W-1:0]  alu_ctrl;
  logic               md_start;
  logic [1:0]         md_op;
  logic               md_busy;
  logic               hilo_we;
  logic               illegal;

  always #5 clk = ~clk;

  alu_control_mc #(
    .FUNCT_W (FUNCT_W),
    .CTRL_W  (CTRL_W),
    .MUL_LAT (MUL_LAT),
    .DIV_LAT (DIV_LAT),
    .CNT_W   (CNT_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .md_start  (md_start),
    .md_op     (md_op),
    .md_busy   (md_busy),
    .hilo_we   (hilo_we),
    .illegal   (illegal)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decode straight from the instruction tables
  typedef struct packed {
    logic [3:0] ctrl;
    logic       ill;
    logic       md;
    logic [1:0] mop;
  } ref_t;

  function automatic ref_t ref_decode(input logic [2:0] op, input logic [5:0] f);
    ref_t       r;
    logic [3:0] opmap [8];
    opmap = '{4'b0010, 4'b0110, 4'b0010, 4'b0000, 4'b0001, 4'b0111, 4'b0011, 4'b1000};
    r = '{ctrl: opmap[op], ill: 1'b0, md: 1'b0, mop: 2'b00};
    if (op == 3'b010) begin
      r.ctrl = 4'b0010;
      if (f >= 6'd24 && f <= 6'd27) begin
        r.md  = 1'b1;
        r.mop = f[1:0];
      end else begin
        case (f)
          6'b100000, 6'b100001: r.ctrl = 4'b0010;
          6'b100010, 6'b100011: r.ctrl = 4'b0110;
          6'b100100: r.ctrl = 4'b0000;
          6'b100101: r.ctrl = 4'b0001;
          6'b100110: r.ctrl = 4'b0011;
          6'b100111: r.ctrl = 4'b1100;
          6'b101010: r.ctrl = 4'b0111;
          6'b101011: r.ctrl = 4'b1000;
          6'b000000: r.ctrl = 4'b1001;
          6'b000010: r.ctrl = 4'b1010;
          6'b000011: r.ctrl = 4'b1011;
          default:   r.ill  = 1'b1;
        endcase
      end
    end
    return r;
  endfunction

  // Model: output slot occupancy plus a count of busy cycles left for mul/div
  ref_t sb [$];
  ref_t cur_ref;
  logic m_ov;
  logic m_start;
  logic [1:0] m_mop;
  int   m_md_cnt;
  logic m_rdy;

  assign cur_ref = ref_decode(alu_op, funct);
  assign m_rdy   = (m_md_cnt == 0) && (!m_ov || out_ready);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ov     <= 1'b0;
      m_start  <= 1'b0;
      m_mop    <= 2'b00;
      m_md_cnt <= 0;
      sb.delete();
    end else if (flush) begin
      m_ov     <= 1'b0;
      m_start  <= 1'b0;
      m_md_cnt <= 0;
      sb.delete();
    end else begin
      m_start <= 1'b0;
      if (m_md_cnt > 0) m_md_cnt <= m_md_cnt - 1;
      if (in_valid && m_rdy) begin
        sb.push_back(cur_ref);
        m_ov <= 1'b1;
        if (cur_ref.md) begin
          m_start  <= 1'b1;
          m_mop    <= cur_ref.mop;
          m_md_cnt <= (cur_ref.mop[1] ? DIV_LAT : MUL_LAT) + 1;
        end
      end else if (out_ready) begin
        m_ov <= 1'b0;
      end
    end
  end

  // Control-signal checker
  always @(negedge clk) begin
    check("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    check("in_ready",  {31'd0, in_ready},  {31'd0, m_rdy});
    check("md_busy",   {31'd0, md_busy},   {31'd0, m_md_cnt != 0});
    check("md_start",  {31'd0, md_start},  {31'd0, m_start});
    check("hilo_we",   {31'd0, hilo_we},   {31'd0, (m_md_cnt == 1) && !flush});
    if (m_start) check("md_op", {30'd0, md_op}, {30'd0, m_mop});
  end

  // Scoreboard monitor
  always @(negedge clk) begin
    if (out_valid) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got alu_ctrl %0h expected no output at %0t", alu_ctrl, $time);
      end else begin
        check("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, sb[0].ctrl});
        check("illegal",  {31'd0, illegal},  {31'd0, sb[0].ill});
        if (out_ready) void'(sb.pop_front());
      end
    end else begin
      check("illegal_idle", {31'd0, illegal}, 32'd0);
    end
  end

  task automatic drive(input logic v, input logic [2:0] op, input logic [5:0] f,
                       input logic rdy, input logic fl);
    in_valid  = v;
    alu_op    = op;
    funct     = f;
    out_ready = rdy;
    flush     = fl;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_alu_ctrl"},  {28'd0, alu_ctrl},  32'd2);
    check({tag, "_md_start"},  {31'd0, md_start},  32'd0);
    check({tag, "_md_op"},     {30'd0, md_op},     32'd0);
    check({tag, "_md_busy"},   {31'd0, md_busy},   32'd0);
    check({tag, "_hilo_we"},   {31'd0, hilo_we},   32'd0);
    check({tag, "_illegal"},   {31'd0, illegal},   32'd0);
  endtask

  logic [5:0] flist [17] = '{6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                             6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011,
                             6'b000000, 6'b000010, 6'b000011, 6'b011000, 6'b011001,
                             6'b011010, 6'b011011};

  initial begin
    repeat (2) @(negedge clk);
    check_reset("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    // XOR through funct decode
    drive(1'b1, 3'b010, 6'b100110, 1'b1, 1'b0);
    drive(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0);

    // Sweep every ALUOp then every single-cycle funct, back to back
    for (int op = 0; op < 8; op++) drive(1'b1, 3'(op), 6'b100000, 1'b1, 1'b0);
    for (int i = 0; i < 13; i++) drive(1'b1, 3'b010, flist[i], 1'b1, 1'b0);
    drive(1'b1, 3'b010, 6'b111111, 1'b1, 1'b0);
    drive(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0);

    // MULT timing
    drive(1'b1, 3'b010, 6'b011000, 1'b1, 1'b0);
    repeat (8) drive(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0);

    // DIVU flushed mid-run; flushed ADD dropped, next ADD accepted
    drive(1'b1, 3'b010, 6'b011011, 1'b1, 1'b0);
    repeat (9) drive(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0);
    drive(1'b1, 3'b000, 6'b000000, 1'b1, 1'b1);
    drive(1'b1, 3'b000, 6'b000000, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0);

    // Back-pressure on a SUB result
    drive(1'b1, 3'b001, 6'b000000, 1'b0, 1'b0);
    repeat (3) drive(1'b1, 3'b011, 6'b000000, 1'b0, 1'b0);
    drive(1'b1, 3'b011, 6'b000000, 1'b1, 1'b0);
    repeat (2) drive(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a DIV run
    drive(1'b1, 3'b010, 6'b011010, 1'b1, 1'b0);
    repeat (5) drive(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    check_reset("midrun_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (40) drive(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0);

    // Randomised traffic
    for (int n = 0; n < 800; n++) begin
      int idx;
      idx = $urandom_range(0, 19);
      drive($urandom_range(0, 3) != 0,
            3'($urandom_range(0, 7)),
            (idx < 17) ? flist[idx] : 6'($urandom),
            $urandom_range(0, 3) != 0,
            $urandom_range(0, 29) == 0);
    end
    repeat (40) drive(1'b0, 3'b000, 6'b000000, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_control_mc.md
Name: alu_control_mc

Overview:
Registered, parametrised ALU control unit for the multi-cycle MIPS datapath. It decodes the main-control ALUOp and R-type funct into a 4-bit ALU control code, covering the extended integer set: XOR, NOR, SLTU, shifts and immediate-logic ops. It also sequences multi-cycle MULT/DIV through a busy FSM that stalls the decode stage until HI/LO is written. It sits between the main control unit and the ALU/mul-div unit, using a valid/ready handshake on both sides.

Parameters:
FUNCT_W, 6, funct field width
CTRL_W, 4, ALU control code width (minimum 4)
MUL_LAT, 4, MULT/MULTU execute cycles (minimum 1)
DIV_LAT, 32, DIV/DIVU execute cycles (minimum 1)
CNT_W, 6, latency counter width; must satisfy 2^CNT_W > max(MUL_LAT, DIV_LAT)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  alu_op/funct valid
in_ready  out  1  unit can accept a decode
alu_op  in  3  ALUOp from main control
funct  in  FUNCT_W  instruction funct field
flush  in  1  synchronous kill of the in-flight op
out_valid  out  1  alu_ctrl/flags valid
out_ready  in  1  downstream accepts output
alu_ctrl  out  CTRL_W  ALU operation code
md_start  out  1  one-cycle mul/div launch pulse
md_op  out  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU
md_busy  out  1  mul/div sequence in progress
hilo_we  out  1  one-cycle HI/LO write enable
illegal  out  1  unknown funct flag, qualified by out_valid

Behaviour:
- Reset (asynchronous, rst_n=0): in FSM state IDLE, counter 0, out_valid=0, alu_ctrl=0010, md_start=0, md_op=00, md_busy=0, hilo_we=0, illegal=0.
- ALU codes: AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLTU 1000, SLL 1001, SRL 1010, SRA 1011, NOR 1100.
- ALUOp map: 000 ADD (lw/sw/addi), 001 SUB (beq/bne), 010 funct decode, 011 AND, 100 OR, 101 SLT, 110 XOR, 111 SLTU.
- Funct map: 100000/100001 ADD; 100010/100011 SUB; 100100 AND; 100101 OR; 100110 XOR; 100111 NOR; 101010 SLT; 101011 SLTU; 000000 SLL; 000010 SRL; 000011 SRA; 011000–011011 MULT/MULTU/DIV/DIVU with alu_ctrl=ADD.
- Any other funct: alu_ctrl=ADD, illegal=1, no mul/div.
- Handshake:
  - in_ready = (state==IDLE) && (!out_valid || out_ready).
  - Accept happens when in_valid && in_ready && !flush.
  - Latency is 1 cycle: out_valid and the decoded fields appear on the cycle after accept.
  - out_valid holds with stable fields until out_ready is sampled high.
  - Back-to-back accepts are allowed for single-cycle ops.
- FSM states: IDLE, MD_RUN, MD_DONE.
  - IDLE: on accept of a mul/div funct, the next cycle asserts md_start=1 and sets md_op. State goes to MD_RUN with counter = LAT-1, where LAT is MUL_LAT or DIV_LAT.
  - MD_RUN: counter decrements each cycle. The cycle the counter reads 0, the state moves to MD_DONE.
  - MD_DONE: hilo_we=1 for exactly one cycle, then IDLE.
  - md_busy = (state != IDLE).
  - Resulting timing for MUL_LAT=4, accept at T: md_start at T+1, hilo_we at T+5, in_ready high again at T+6.
- flush:
  - Forces IDLE, counter 0, out_valid=0 and md_start=0 on the next edge.
  - hilo_we is not asserted for a flushed op, including when flush coincides with MD_DONE.
  - flush wins over a simultaneous accept; that input is dropped.
- Reset mid-sequence aborts immediately; no hilo_we pulse follows.
- in_ready stays low throughout MD_RUN/MD_DONE regardless of in_valid.

Decomposition:
- Shared package alu_pkg holds:
  - ALU code localparams (ALU_AND…ALU_NOR)
  - ALUOp localparams
  - funct localparams
  - md_op encodings
  - FSM state encoding
- One natural sub-module, alu_funct_dec: purely combinational (alu_op, funct) -> (alu_ctrl, is_md, md_op, illegal).
- The top level holds the output register, handshake and mul/div FSM/counter.

Test Plan:
1. Reset release, then alu_op=010/funct=100110 with in_valid=1, out_ready=1 -> next cycle out_valid=1, alu_ctrl=0011, illegal=0; in_ready stays 1.
2. Sweep every ALUOp and every funct entry, back-to-back -> codes match the map one cycle later with no bubbles; funct=111111 -> alu_ctrl=0010, illegal=1.
3. MULT (funct 011000) accepted at T, MUL_LAT=4 -> md_start pulse at T+1 with md_op=00; md_busy high T+1..T+5; hilo_we only at T+5; in_ready low T+1..T+5, high at T+6.
4. DIVU with DIV_LAT=32, flush asserted at accept+10 -> state IDLE next cycle, md_busy=0, hilo_we never asserted, new ADD accepted the cycle after.
5. out_ready=0 for 3 cycles with out_valid=1 (SUB) -> alu_ctrl stays 0110, in_ready=0, the next input is not consumed until out_ready=1.
6. rst_n pulsed low mid-MD_RUN -> all outputs at reset values immediately (asynchronous); no hilo_we after release.
